// File: rtl/game_tick_gen.sv
// game_tick_gen: fast/slow/level-scaled drop enable strobes, all on CLOCK_50M.
module game_tick_gen #(
   parameter int CNT_W     = 32,
   parameter int FAST_DIV  = 5000000,
   parameter int SLOW_MULT = 6,
   parameter int DROP_BASE = 25000000,
   parameter int DROP_STEP = 2000000,
   parameter int DROP_MIN  = 2500000,
   parameter int LEVEL_W   = 4
) (
   input  logic               CLOCK_50M,
   input  logic               reset_n,
   input  logic               enable,
   input  logic               pause,
   input  logic               drop_restart,
   input  logic [LEVEL_W-1:0] level,
   output logic               tick_fast,
   output logic               tick_slow,
   output logic               tick_drop,
   output logic               sq_fast,
   output logic               level_sat
);
   localparam int PW = CNT_W + LEVEL_W;
   if (FAST_DIV < 2 || SLOW_MULT < 1 || DROP_MIN < 2 || DROP_MIN > DROP_BASE ||
       (longint'(FAST_DIV) >> CNT_W) != 0 || (longint'(SLOW_MULT) >> CNT_W) != 0 ||
       (longint'(DROP_BASE) >> CNT_W) != 0 || (longint'(DROP_STEP) >> CNT_W) != 0) begin : g_param_err
      $error("game_tick_gen: illegal parameter set");
   end
   logic [CNT_W-1:0] fast_cnt_q, fast_cnt_d, slow_cnt_q, slow_cnt_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d, drop_period_q, drop_period_d;
   logic             tick_fast_q, tick_fast_d, tick_slow_q, tick_slow_d, tick_drop_q, tick_drop_d;
   logic             sq_q, sq_d, sat_q, sat_d;
   logic [PW-1:0]    lvl_step, diff;
   logic [CNT_W-1:0] next_period;
   logic             fast_wrap, slow_wrap, drop_wrap, run_drop, reload;
   // Wide product and subtraction so no level value can wrap the period.
   always_comb begin
      lvl_step    = PW'(level) * PW'(DROP_STEP);
      diff        = PW'(DROP_BASE) - lvl_step;
      next_period = (lvl_step > PW'(DROP_BASE - DROP_MIN)) ? CNT_W'(DROP_MIN) : diff[CNT_W-1:0];
   end
   always_comb begin
      fast_wrap     = fast_cnt_q == CNT_W'(FAST_DIV - 1);
      slow_wrap     = slow_cnt_q == CNT_W'(SLOW_MULT - 1);
      drop_wrap     = drop_cnt_q >= drop_period_q - CNT_W'(1);
      run_drop      = enable && !pause;
      tick_fast_d   = enable && fast_wrap;
      fast_cnt_d    = !enable ? fast_cnt_q : fast_wrap ? '0 : fast_cnt_q + CNT_W'(1);
      sq_d          = sq_q ^ tick_fast_d;
      tick_slow_d   = tick_fast_d && slow_wrap;
      slow_cnt_d    = !tick_fast_d ? slow_cnt_q : slow_wrap ? '0 : slow_cnt_q + CNT_W'(1);
      tick_drop_d   = !drop_restart && run_drop && drop_wrap;
      drop_cnt_d    = drop_restart ? '0 : !run_drop ? drop_cnt_q : drop_wrap ? '0 : drop_cnt_q + CNT_W'(1);
      reload        = drop_restart || tick_drop_d;
      drop_period_d = reload ? next_period : drop_period_q;
      sat_d         = reload ? (next_period == CNT_W'(DROP_MIN)) : sat_q;
   end
   always_ff @(posedge CLOCK_50M or negedge reset_n) begin
      if (!reset_n) begin
         fast_cnt_q    <= '0;
         slow_cnt_q    <= '0;
         drop_cnt_q    <= '0;
         drop_period_q <= CNT_W'(DROP_BASE);
         tick_fast_q   <= 1'b0;
         tick_slow_q   <= 1'b0;
         tick_drop_q   <= 1'b0;
         sq_q          <= 1'b0;
         sat_q         <= 1'b0;
      end else begin
         fast_cnt_q    <= fast_cnt_d;
         slow_cnt_q    <= slow_cnt_d;
         drop_cnt_q    <= drop_cnt_d;
         drop_period_q <= drop_period_d;
         tick_fast_q   <= tick_fast_d;
         tick_slow_q   <= tick_slow_d;
         tick_drop_q   <= tick_drop_d;
         sq_q          <= sq_d;
         sat_q         <= sat_d;
      end
   end
   assign tick_fast = tick_fast_q;
   assign tick_slow = tick_slow_q;
   assign tick_drop = tick_drop_q;
   assign sq_fast   = sq_q;
   assign level_sat = sat_q;
endmodule

// File: tb/tb_game_tick_gen.sv
// tb_game_tick_gen: scoreboard of per-cycle expected outputs plus directed tick-edge checks.
module tb_game_tick_gen;
   localparam int CNT_W = 32, FAST_DIV = 4, SLOW_MULT = 3, DROP_BASE = 20, DROP_STEP = 4, DROP_MIN = 6, LEVEL_W = 4;
   typedef struct packed {logic f, s, d, q, sat;} out_t;
   logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, pa = 1'b0, rs = 1'b0;
   logic [LEVEL_W-1:0] lvl = '0;
   logic tick_fast, tick_slow, tick_drop, sq_fast, level_sat;
   out_t exp_q[$];
   int errors = 0, checks = 0, edge_n = 0;
   int drops[$], fasts[$], slows[$];
   int m_fc, m_sc, m_dc, m_dp;
   bit m_sat, m_sq;

   game_tick_gen #(.CNT_W(CNT_W), .FAST_DIV(FAST_DIV), .SLOW_MULT(SLOW_MULT), .DROP_BASE(DROP_BASE),
                   .DROP_STEP(DROP_STEP), .DROP_MIN(DROP_MIN), .LEVEL_W(LEVEL_W)) dut (
      .CLOCK_50M(clk), .reset_n(rst_n), .enable(en), .pause(pa), .drop_restart(rs), .level(lvl),
      .tick_fast(tick_fast), .tick_slow(tick_slow), .tick_drop(tick_drop), .sq_fast(sq_fast), .level_sat(level_sat));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
      end
   endtask

   function automatic int period_for(input int l);
      int s = l * DROP_STEP;
      return (s > DROP_BASE - DROP_MIN) ? DROP_MIN : DROP_BASE - s;
   endfunction

   task automatic model_reset();
      m_fc = 0; m_sc = 0; m_dc = 0; m_dp = DROP_BASE; m_sat = 0; m_sq = 0;
   endtask

   task automatic step(input bit e, input bit p, input bit r, input int l);
      out_t o, got, want;
      o = '0;
      en = e; pa = p; rs = r; lvl = LEVEL_W'(l);
      if (e) begin
         if (m_fc == FAST_DIV - 1) begin
            m_fc = 0; o.f = 1; m_sq = !m_sq;
            if (m_sc == SLOW_MULT - 1) begin m_sc = 0; o.s = 1; end else m_sc++;
         end else m_fc++;
      end
      if (r) begin
         m_dc = 0; m_dp = period_for(l); m_sat = (m_dp == DROP_MIN);
      end else if (e && !p) begin
         if (m_dc >= m_dp - 1) begin
            m_dc = 0; o.d = 1; m_dp = period_for(l); m_sat = (m_dp == DROP_MIN);
         end else m_dc++;
      end
      o.q = m_sq; o.sat = m_sat;
      exp_q.push_back(o);
      @(posedge clk); #1;
      edge_n++;
      want = exp_q.pop_front();
      got = {tick_fast, tick_slow, tick_drop, sq_fast, level_sat};
      check($sformatf("outs@%0d", edge_n), 32'(got), 32'(want));
      if (tick_drop) drops.push_back(edge_n);
      if (tick_fast) fasts.push_back(edge_n);
      if (tick_slow) slows.push_back(edge_n);
   endtask

   task automatic run(input int n, input bit e, input bit p, input int l);
      repeat (n) step(e, p, 0, l);
   endtask

   task automatic do_reset();
      rst_n = 0; en = 0; pa = 0; rs = 0;
      exp_q.delete(); model_reset();
      @(posedge clk); #1;
      check("reset_outs", 32'({tick_fast, tick_slow, tick_drop, sq_fast, level_sat}), 32'd0);
      @(negedge clk); rst_n = 1;
      edge_n = 0; drops.delete(); fasts.delete(); slows.delete();
   endtask

   initial begin
      int r_edge;
      // 1: basic cadence at level 0
      do_reset();
      run(40, 1, 0, 0);
      check("t1_fast0", fasts[0], 4);
      check("t1_fast1", fasts[1], 8);
      check("t1_slow0", slows[0], 12);
      check("t1_slow1", slows[1], 24);
      check("t1_ndrop", drops.size(), 2);
      check("t1_drop0", drops[0], 20);
      check("t1_drop1", drops[1], 40);
      // 2: level change mid-interval applies from next interval
      do_reset();
      run(10, 1, 0, 0);
      run(34, 1, 0, 2);
      check("t2_drop0", drops[0], 20);
      check("t2_drop1", drops[1], 32);
      check("t2_drop2", drops[2], 44);
      check("t2_sat", level_sat, 0);
      // 3: saturation at level 5 and at level 15
      do_reset();
      run(32, 1, 0, 5);
      check("t3_drop1", drops[1], 26);
      check("t3_drop2", drops[2], 32);
      check("t3_sat", level_sat, 1);
      run(12, 1, 0, 15);
      check("t3_drop3", drops[3], 38);
      check("t3_drop4", drops[4], 44);
      check("t3_sat15", level_sat, 1);
      // 4: pause shifts only the drop channel
      do_reset();
      run(4, 1, 0, 0);
      run(5, 1, 1, 0);
      run(16, 1, 0, 0);
      check("t4_drop0", drops[0], 25);
      check("t4_fast4", fasts[4], 20);
      // 5: restarts mid-interval, on the wrap edge, and while disabled
      do_reset();
      run(14, 1, 0, 0);
      step(1, 0, 1, 0);
      run(20, 1, 0, 0);
      check("t5_ndrop", drops.size(), 1);
      check("t5_drop0", drops[0], 35);
      do_reset();
      run(19, 1, 0, 0);
      step(1, 0, 1, 0);
      run(20, 1, 0, 0);
      check("t5_wrap_ndrop", drops.size(), 1);
      check("t5_wrap_drop0", drops[0], 40);
      run(7, 1, 0, 0);
      run(2, 0, 0, 0);
      step(0, 0, 1, 0);
      r_edge = edge_n;
      run(3, 0, 0, 0);
      run(20, 1, 0, 0);
      check("t5_dis_drop", drops[drops.size() - 1], r_edge + 3 + 20);
      // 6: asynchronous reset between edges, then enable gap
      do_reset();
      run(23, 1, 0, 5);
      check("t6_pre_sq", sq_fast, 1);
      check("t6_pre_sat", level_sat, 1);
      #2 rst_n = 0;
      #1 check("t6_async", 32'({tick_fast, tick_slow, tick_drop, sq_fast, level_sat}), 32'd0);
      do_reset();
      run(10, 1, 0, 0);
      run(7, 0, 0, 0);
      run(10, 1, 0, 0);
      check("t6_fast2", fasts[2], 19);
      check("t6_drop0", drops[0], 27);
      check("t6_qempty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/game_tick_gen.md
Name: game_tick_gen

Overview:
Parametrised multi-channel tick generator for the Tetris VGA game. It produces single-cycle enable strobes instead of derived clocks, so all game logic stays on CLOCK_50M. There are three channels:
- a fast tick (input/animation rate);
- a slow tick (cascaded count of fast ticks);
- a drop tick whose period shortens with game level, with pause and restart controls.

Parameters:
CNT_W, 32, width of all cycle counters and period registers
FAST_DIV, 5000000, CLOCK_50M cycles per fast tick (>=2)
SLOW_MULT, 6, fast ticks per slow tick (>=1)
DROP_BASE, 25000000, drop period in cycles at level 0
DROP_STEP, 2000000, period reduction per level
DROP_MIN, 2500000, minimum drop period in cycles (>=2, <=DROP_BASE)
LEVEL_W, 4, width of level input

Ports:
CLOCK_50M  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
enable  in  1  global run enable; low freezes all counters
pause  in  1  freezes drop channel only
drop_restart  in  1  single-cycle request: restart drop interval (new piece spawned)
level  in  LEVEL_W  current game level, unsigned
tick_fast  out  1  one-cycle strobe every FAST_DIV enabled cycles
tick_slow  out  1  one-cycle strobe every SLOW_MULT fast ticks
tick_drop  out  1  one-cycle strobe per drop interval
sq_fast  out  1  50% square wave, toggles on each fast tick (LED/debug)
level_sat  out  1  high while latched drop period equals DROP_MIN

Behaviour:
- Reset (reset_n low, asynchronous): all counters 0; tick_* 0; sq_fast 0; drop_period = DROP_BASE; level_sat 0. The level input is not sampled during reset.
- All outputs are registered. tick_* are high for exactly one cycle and never stretch.
- Fast channel, on each edge with enable=1:
  - if fast_cnt == FAST_DIV-1: fast_cnt <= 0, tick_fast <= 1, sq_fast toggles;
  - else fast_cnt++ and tick_fast <= 0.
  - First tick_fast is high after edge FAST_DIV following reset release.
- Slow channel: slow_cnt advances on the same edge that sets tick_fast. It wraps at SLOW_MULT-1, and tick_slow asserts in the same cycle as the coinciding tick_fast. With SLOW_MULT=1, tick_slow equals tick_fast.
- enable=0: every counter, sq_fast and drop_period hold; all tick_* are driven 0 next cycle. Resuming continues from the held counts.
- Drop period calculation:
  - next_period = DROP_BASE - level*DROP_STEP, computed in CNT_W+LEVEL_W bits.
  - If level*DROP_STEP > DROP_BASE-DROP_MIN, next_period = DROP_MIN. No wrap-around or underflow for any level value.
- Drop period latching:
  - drop_period and level_sat (level_sat = next_period==DROP_MIN) load only at a drop wrap or on drop_restart.
  - A level change mid-interval therefore takes effect from the next interval.
- Drop channel, priority high to low:
  1. drop_restart=1 (honoured even if enable=0 or pause=1): drop_cnt <= 0, reload drop_period/level_sat, tick_drop <= 0. A restart coinciding with a would-be wrap suppresses that tick.
  2. enable=0 or pause=1: drop_cnt holds, tick_drop <= 0.
  3. Otherwise:
     - if drop_cnt >= drop_period-1: drop_cnt <= 0, tick_drop <= 1, reload period;
     - else drop_cnt++, tick_drop <= 0.
- pause affects only the drop channel; fast/slow/sq keep running.
- Counter widths: all compares are full CNT_W width. Parameters are required to be < 2^CNT_W; violations are a static elaboration-time error (checked in simulation).

Test Plan:
Bench parameters: FAST_DIV=4, SLOW_MULT=3, DROP_BASE=20, DROP_STEP=4, DROP_MIN=6, LEVEL_W=4.
1. Release reset, enable=1, level=0 -> tick_fast high after edges 4,8,12,...; tick_slow after edges 12,24; sq_fast 0->1 at edge 4, 1->0 at 8; tick_drop after edges 20,40.
2. level 0->2 at edge 10 -> tick_drop still at edge 20, then at edges 32,44 (period 12); level_sat stays 0.
3. level=5 -> period 6, level_sat=1 after next wrap. level=15 (15*4=60>20) -> period 6, no underflow, tick every 6 cycles.
4. level=0, pause high for edges 5-9 (5 cycles) -> tick_drop moves from edge 20 to 25. tick_fast remains at 4,8,12,16,20.
5. drop_restart at edge 15 -> no tick at 20, next tick_drop at edge 35. Restart on edge 20 (wrap edge) -> no tick, next at 40. Restart while enable=0 -> drop_cnt cleared.
6. Assert reset_n mid-interval between clock edges -> all outputs 0 immediately, without waiting for an edge. enable=0 for 7 cycles -> ticks 0 and counts frozen; sequence resumes shifted by exactly 7 cycles.
